r8051_mem_sys: RTL and testbench
================================

# r8051_mem_sys

Synthesizable memory and peripheral responder for the r8051 core, generalising the simulation memory models into one parametrised block. It serves program fetch (ROM), internal data RAM, external XDATA RAM and a minimal SFR space (SCON/SBUF) with configurable wait states and explicit valid strobes. SBUF writes feed a transmit queue drained through a valid/ready stream. It sits directly on the r8051 `rom_*` / `ram_*` ports in FPGA builds and in the regression bench.

## Interface
- `ROM_AW`, 16: ROM address bits; depth is 2^ROM_AW bytes.
- `XDATA_AW`, 12: XDATA address bits; depth is 2^XDATA_AW bytes.
- `ROM_WAIT`, 0: extra cycles before `rom_vld`, range 0..15.
- `XDATA_WAIT`, 1: extra cycles before `ram_rd_vld` on XDATA reads, range 0..15.
- `TXQ_DEPTH`, 8: transmit queue entries; must be a power of 2, at least 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous reset, active-high.
- `rom_en` in 1; `rom_addr` in 16; `rom_byte` out 8; `rom_vld` out 1.
- `ram_rd_en_data`, `ram_rd_en_sfr`, `ram_rd_en_xdata` in 1 each; `ram_rd_addr` in 16; `ram_rd_byte` out 8; `ram_rd_vld` out 1.
- `ram_wr_en_data`, `ram_wr_en_sfr`, `ram_wr_en_xdata` in 1 each; `ram_wr_addr` in 16; `ram_wr_byte` in 8.
- `tx_valid` out 1; `tx_data` out 8; `tx_ready` in 1: transmit stream.
- `sim_done` out 1: sticky end-of-test flag.
- `sfr_err` out 1: one-cycle pulse on an access to an unmapped SFR.

## Operation
- **ROM fetch.**
  - `rom_en` is accepted when no fetch is pending; the address is sampled at acceptance.
  - With `ROM_WAIT=0`, fetches are fully pipelined, one per cycle.
  - With `ROM_WAIT>0`, `rom_en` arriving while a fetch is pending is ignored. The requester holds `rom_en` and `rom_addr` until it sees `rom_vld`.
  - Address bits above `ROM_AW` are ignored.
- **Read port.**
  - If several read enables are high in the same cycle, priority is sfr > xdata > data. One access is served and `ram_rd_vld` pulses once for it.
  - An XDATA read while an XDATA read is pending is ignored.
- **DATA RAM.** Indexed by `ram_rd_addr[7:0]` / `ram_wr_addr[7:0]` (see Configuration). Reads are read-first: a same-cycle write to the same address returns the old byte.
- **XDATA RAM.**
  - Reads and writes use the low `XDATA_AW` address bits.
  - A write to address all-ones with `ram_wr_byte[0]=1` sets `sim_done` and does not store the byte.
- **SFR map.**
  - SCON 0x98 reads {OVF, 5'b0, TI, RI}.
    - TI = queue not full.
    - RI = 0.
    - OVF = sticky overflow bit.
  - Writing SCON with bit7=0 clears OVF. All other SCON write bits are ignored.
  - SBUF 0x99 reads 0x00.
  - A write to SBUF pushes `ram_wr_byte` into the queue. If the queue is full and no pop happens in that cycle, the byte is dropped and OVF is set. A push and a pop in the same cycle while full are both accepted.
  - Any other SFR read returns 0x00. Any other SFR write is ignored. Either case pulses `sfr_err`.
- **Transmit stream.** `tx_valid` = queue not empty and `tx_data` = head entry. An entry pops when `tx_valid & tx_ready`.

## Timing
- Reset values: `rom_byte`, `ram_rd_byte` and `tx_data` are 0x00; `rom_vld`, `ram_rd_vld`, `tx_valid`, `sim_done` and `sfr_err` are 0. Queue empty, OVF=0, all wait counters idle. RAM contents are not reset.
- Reset mid-access cancels every pending fetch or read with no `vld` pulse, and empties the queue.
- A ROM fetch accepted in cycle N: `rom_vld` is 1 in cycle N+1+ROM_WAIT for exactly one cycle, with `rom_byte` valid in that cycle.
- A DATA or SFR read enabled in cycle N: `ram_rd_vld` and `ram_rd_byte` in cycle N+1.
- An XDATA read enabled in cycle N: `ram_rd_vld` and `ram_rd_byte` in cycle N+1+XDATA_WAIT.
- `rom_byte` and `ram_rd_byte` hold their last value while the matching `vld` is low.
- Writes take effect at the end of the enable cycle.
- A push in cycle N: `tx_valid` rises in cycle N+1.
- `sfr_err` pulses in cycle N+1 after the offending enable.
- `sim_done` rises in cycle N+1 after the magic write and clears only on `rst`.

## Configuration
- `R8051_TYPE8052_EN` defined: DATA RAM is 256 bytes and address bit 7 is used.
- Undefined: DATA RAM is 128 bytes and addresses 0x80–0xFF alias onto 0x00–0x7F.

## Structure
- Package `r8051_mem_pkg` holds:
  - the constants `SCON_ADDR` (8'h98) and `SBUF_ADDR` (8'h99);
  - the SCON bit indices `SCON_OVF`, `SCON_TI`, `SCON_RI`;
  - the wait-counter width.
- Sub-module `r8051_txq` is a synchronous FIFO with push/pop, full/empty and a count output, parametrised by `TXQ_DEPTH`.

## Test plan
- ROM_WAIT=0: `rom_en` every cycle on addresses 0..3 holding 0x02,0x00,0x30,0xE4 → `rom_vld` high in cycles 1..4 with those bytes in order.
- ROM_WAIT=2, XDATA_WAIT=3: fetch 0x0010 in cycle 0 → `rom_vld` in cycle 3 only. XDATA read in cycle 0 → `ram_rd_vld` in cycle 4 only.
- DATA write 0x55→0x20 while reading 0x20 in the same cycle → returns the old value; the next read returns 0x55. Without the macro, a read of 0xA0 returns 0x55.
- `tx_ready`=0, 9 SBUF writes with TXQ_DEPTH=8 → SCON reads 0x80 (OVF set, TI=0). Then hold `tx_ready`=1 → the first 8 bytes stream in order and SCON reads 0x82.
- XDATA write 0x01 to 0xFFF → `sim_done`=1 next cycle and the location is unchanged. SFR read 0x80 → 0x00 with an `sfr_err` pulse.
- Assert `rst` during a pending XDATA read with 3 bytes queued → no `ram_rd_vld`, `tx_valid`=0, SCON reads 0x02.

Source files
------------

// File: rtl/r8051_mem_pkg.sv
// Shared constants for the r8051 memory/peripheral responder: SFR addresses,
// SCON bit positions and the wait-counter width.
package r8051_mem_pkg;

    localparam logic [7:0] SCON_ADDR = 8'h98;
    localparam logic [7:0] SBUF_ADDR = 8'h99;

    localparam int SCON_OVF = 7;
    localparam int SCON_TI  = 1;
    localparam int SCON_RI  = 0;

    // Wide enough for wait settings 0..15.
    localparam int WAIT_W = 4;

    function automatic logic [7:0] scon_value(input logic ovf, input logic ti);
        logic [7:0] v;
        v           = 8'h00;
        v[SCON_OVF] = ovf;
        v[SCON_TI]  = ti;
        v[SCON_RI]  = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/r8051_mem_sys_txq.sv
// Transmit queue behind SBUF: synchronous FIFO; a push while full is accepted
// only when a pop happens in the same cycle.
module r8051_txq
#(
    parameter int TXQ_DEPTH = 8
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [7:0]                   i_data,
    input  logic                         i_pop,
    output logic [7:0]                   o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(TXQ_DEPTH):0]   o_count
);

    localparam int PW = $clog2(TXQ_DEPTH);

    logic [7:0]  r_mem [TXQ_DEPTH];
    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    logic        w_pop_ok;
    logic        w_push_ok;

    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

    // Extra pointer bit distinguishes full from empty.
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (o_count == '0);
    assign o_full  = o_count[PW];
    assign o_data  = o_empty ? 8'h00 : r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/r8051_mem_sys.sv
// ROM / DATA / XDATA / SFR responder for the r8051 core with wait states and a
// SBUF transmit queue. Define R8051_TYPE8052_EN for the 256-byte DATA RAM.
module r8051_mem_sys
    import r8051_mem_pkg::*;
#(
    parameter int ROM_AW     = 16,
    parameter int XDATA_AW   = 12,
    parameter int ROM_WAIT   = 0,
    parameter int XDATA_WAIT = 1,
    parameter int TXQ_DEPTH  = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_en,
    input  logic [15:0] rom_addr,
    output logic [7:0]  rom_byte,
    output logic        rom_vld,
    input  logic        ram_rd_en_data,
    input  logic        ram_rd_en_sfr,
    input  logic        ram_rd_en_xdata,
    input  logic [15:0] ram_rd_addr,
    output logic [7:0]  ram_rd_byte,
    output logic        ram_rd_vld,
    input  logic        ram_wr_en_data,
    input  logic        ram_wr_en_sfr,
    input  logic        ram_wr_en_xdata,
    input  logic [15:0] ram_wr_addr,
    input  logic [7:0]  ram_wr_byte,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        sim_done,
    output logic        sfr_err
);

`ifdef R8051_TYPE8052_EN
    localparam int DATA_AW = 8;
`else
    localparam int DATA_AW = 7;
`endif
    localparam int CW = $clog2(TXQ_DEPTH) + 1;
    localparam logic [CW-1:0] TXQ_FULL_CNT = CW'(TXQ_DEPTH);

    logic [7:0] r_rom_mem   [2**ROM_AW];
    logic [7:0] r_data_mem  [2**DATA_AW];
    logic [7:0] r_xdata_mem [2**XDATA_AW];

    logic [WAIT_W-1:0] r_rom_cnt, r_x_cnt;
    logic [7:0]        r_rom_byte, r_rd_byte;
    logic              r_rom_vld, r_rd_vld, r_ovf, r_sim_done, r_sfr_err;

    logic w_rom_accept, w_rom_fire, w_x_fire;
    logic w_sel_sfr, w_sel_x, w_sel_data;
    logic w_scon_wr, w_sbuf_wr, w_magic, w_sfr_bad, w_pop;
    logic w_txq_full, w_txq_empty, w_unused_bits;
    logic [7:0] w_rom_byte, w_x_byte, w_sfr_rd_byte, w_txq_data;
    logic [CW-1:0] w_txq_count;
    logic [ROM_AW-1:0]   w_rom_idx;
    logic [XDATA_AW-1:0] w_x_rd_idx, w_x_wr_idx;

    assign w_unused_bits = ^{rom_addr, ram_rd_addr, ram_wr_addr};

    assign w_rom_idx    = rom_addr[ROM_AW-1:0];
    assign w_x_rd_idx   = ram_rd_addr[XDATA_AW-1:0];
    assign w_x_wr_idx   = ram_wr_addr[XDATA_AW-1:0];
    assign w_rom_accept = rom_en && (r_rom_cnt == '0);

    // Read-port arbitration: sfr > xdata > data; a busy XDATA read drops a new one.
    assign w_sel_sfr  = ram_rd_en_sfr;
    assign w_sel_x    = !ram_rd_en_sfr && ram_rd_en_xdata && (r_x_cnt == '0);
    assign w_sel_data = !ram_rd_en_sfr && !ram_rd_en_xdata && ram_rd_en_data;

    generate
        if (ROM_WAIT == 0) begin : g_rom_nowait
            assign w_rom_fire = w_rom_accept;
            assign w_rom_byte = r_rom_mem[w_rom_idx];
            always_ff @(posedge clk) r_rom_cnt <= '0;
        end else begin : g_rom_wait
            logic [7:0] r_rom_data;
            always_ff @(posedge clk) begin
                if (w_rom_accept) r_rom_data <= r_rom_mem[w_rom_idx];
            end
            always_ff @(posedge clk) begin
                if (rst)                  r_rom_cnt <= '0;
                else if (w_rom_accept)    r_rom_cnt <= WAIT_W'(ROM_WAIT);
                else if (r_rom_cnt != '0) r_rom_cnt <= r_rom_cnt - WAIT_W'(1);
            end
            assign w_rom_fire = (r_rom_cnt == WAIT_W'(1));
            assign w_rom_byte = r_rom_data;
        end

        if (XDATA_WAIT == 0) begin : g_x_nowait
            assign w_x_fire = w_sel_x;
            assign w_x_byte = r_xdata_mem[w_x_rd_idx];
            always_ff @(posedge clk) r_x_cnt <= '0;
        end else begin : g_x_wait
            logic [7:0] r_x_data;
            always_ff @(posedge clk) begin
                if (w_sel_x) r_x_data <= r_xdata_mem[w_x_rd_idx];
            end
            always_ff @(posedge clk) begin
                if (rst)                r_x_cnt <= '0;
                else if (w_sel_x)       r_x_cnt <= WAIT_W'(XDATA_WAIT);
                else if (r_x_cnt != '0) r_x_cnt <= r_x_cnt - WAIT_W'(1);
            end
            assign w_x_fire = (r_x_cnt == WAIT_W'(1));
            assign w_x_byte = r_x_data;
        end
    endgenerate

    assign w_sfr_rd_byte = (ram_rd_addr[7:0] == SCON_ADDR)
                         ? scon_value(r_ovf, w_txq_count != TXQ_FULL_CNT) : 8'h00;
    assign w_scon_wr = ram_wr_en_sfr && (ram_wr_addr[7:0] == SCON_ADDR);
    assign w_sbuf_wr = ram_wr_en_sfr && (ram_wr_addr[7:0] == SBUF_ADDR);
    assign w_sfr_bad = (ram_rd_en_sfr && (ram_rd_addr[7:0] != SCON_ADDR) && (ram_rd_addr[7:0] != SBUF_ADDR))
                     || (ram_wr_en_sfr && !w_scon_wr && !w_sbuf_wr);
    assign w_magic   = ram_wr_en_xdata && (w_x_wr_idx == '1) && ram_wr_byte[0];
    assign w_pop     = !w_txq_empty && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_vld  <= 1'b0;
            r_rom_byte <= 8'h00;
            r_rd_vld   <= 1'b0;
            r_rd_byte  <= 8'h00;
        end else begin
            r_rom_vld <= w_rom_fire;
            if (w_rom_fire) r_rom_byte <= w_rom_byte;
            r_rd_vld <= w_x_fire || w_sel_sfr || w_sel_data;
            if (w_x_fire)        r_rd_byte <= w_x_byte;
            else if (w_sel_sfr)  r_rd_byte <= w_sfr_rd_byte;
            else if (w_sel_data) r_rd_byte <= r_data_mem[ram_rd_addr[DATA_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wr_en_data) r_data_mem[ram_wr_addr[DATA_AW-1:0]] <= ram_wr_byte;
    end

    // The end-of-test magic write is a side channel, not a store.
    always_ff @(posedge clk) begin
        if (ram_wr_en_xdata && !w_magic) r_xdata_mem[w_x_wr_idx] <= ram_wr_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_sim_done <= 1'b0;
            r_sfr_err  <= 1'b0;
        end else begin
            r_sfr_err <= w_sfr_bad;
            if (w_magic) r_sim_done <= 1'b1;
            if (w_sbuf_wr && w_txq_full && !w_pop)          r_ovf <= 1'b1;
            else if (w_scon_wr && !ram_wr_byte[SCON_OVF])   r_ovf <= 1'b0;
        end
    end

    r8051_txq #(.TXQ_DEPTH(TXQ_DEPTH)) u_txq (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_sbuf_wr),
        .i_data  (ram_wr_byte),
        .i_pop   (w_pop),
        .o_data  (w_txq_data),
        .o_full  (w_txq_full),
        .o_empty (w_txq_empty),
        .o_count (w_txq_count)
    );

    assign rom_byte    = r_rom_byte;
    assign rom_vld     = r_rom_vld;
    assign ram_rd_byte = r_rd_byte;
    assign ram_rd_vld  = r_rd_vld;
    assign tx_valid    = !w_txq_empty;
    assign tx_data     = w_txq_data;
    assign sim_done    = r_sim_done;
    assign sfr_err     = r_sfr_err;

endmodule

// File: tb/tb_r8051_mem_sys.sv
// Bench for r8051_mem_sys: two instances (no-wait and wait-state builds) share
// one stimulus stream; expectations come from arrays and a queue model.
module tb_r8051_mem_sys;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_en = 1'b0;
    logic [15:0] rom_addr = 16'h0000;
    logic        ram_rd_en_data = 1'b0, ram_rd_en_sfr = 1'b0, ram_rd_en_xdata = 1'b0;
    logic [15:0] ram_rd_addr = 16'h0000;
    logic        ram_wr_en_data = 1'b0, ram_wr_en_sfr = 1'b0, ram_wr_en_xdata = 1'b0;
    logic [15:0] ram_wr_addr = 16'h0000;
    logic [7:0]  ram_wr_byte = 8'h00;
    logic        tx_ready = 1'b0;

    logic [7:0] a_rom_byte, b_rom_byte, a_rd_byte, b_rd_byte, a_tx_data, b_tx_data;
    logic       a_rom_vld, b_rom_vld, a_rd_vld, b_rd_vld, a_tx_valid, b_tx_valid;
    logic       a_sim_done, b_sim_done, a_sfr_err, b_sfr_err;

    int checks = 0;
    int errors = 0;

`ifdef R8051_TYPE8052_EN
    localparam logic [7:0] DMASK = 8'hFF;
`else
    localparam logic [7:0] DMASK = 8'h7F;
`endif
    localparam logic [7:0] SCON = 8'h98;
    localparam logic [7:0] SBUF = 8'h99;

    logic [7:0] data_model  [256];
    logic [7:0] xdata_model [4096];
    logic [7:0] txq_model   [$];
    logic [7:0] rom_img     [4];

    always #5 clk = ~clk;

    r8051_mem_sys #(.ROM_WAIT(0), .XDATA_WAIT(1)) dut_a (
        .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_byte(a_rom_byte), .rom_vld(a_rom_vld),
        .ram_rd_en_data(ram_rd_en_data), .ram_rd_en_sfr(ram_rd_en_sfr),
        .ram_rd_en_xdata(ram_rd_en_xdata), .ram_rd_addr(ram_rd_addr),
        .ram_rd_byte(a_rd_byte), .ram_rd_vld(a_rd_vld),
        .ram_wr_en_data(ram_wr_en_data), .ram_wr_en_sfr(ram_wr_en_sfr),
        .ram_wr_en_xdata(ram_wr_en_xdata), .ram_wr_addr(ram_wr_addr),
        .ram_wr_byte(ram_wr_byte), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
        .tx_ready(tx_ready), .sim_done(a_sim_done), .sfr_err(a_sfr_err)
    );

    r8051_mem_sys #(.ROM_WAIT(2), .XDATA_WAIT(3)) dut_b (
        .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_byte(b_rom_byte), .rom_vld(b_rom_vld),
        .ram_rd_en_data(ram_rd_en_data), .ram_rd_en_sfr(ram_rd_en_sfr),
        .ram_rd_en_xdata(ram_rd_en_xdata), .ram_rd_addr(ram_rd_addr),
        .ram_rd_byte(b_rd_byte), .ram_rd_vld(b_rd_vld),
        .ram_wr_en_data(ram_wr_en_data), .ram_wr_en_sfr(ram_wr_en_sfr),
        .ram_wr_en_xdata(ram_wr_en_xdata), .ram_wr_addr(ram_wr_addr),
        .ram_wr_byte(ram_wr_byte), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
        .tx_ready(tx_ready), .sim_done(b_sim_done), .sfr_err(b_sfr_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
        ram_wr_en_sfr = 1'b1; ram_wr_addr = {8'h00, addr}; ram_wr_byte = data;
        step();
        ram_wr_en_sfr = 1'b0;
    endtask

    task automatic sfr_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        ram_rd_en_sfr = 1'b1; ram_rd_addr = {8'h00, addr};
        step();
        ram_rd_en_sfr = 1'b0;
        chk({tag, "_vld"}, a_rd_vld, 1);
        chk(tag, a_rd_byte, exp);
        $display("txn sfr_read  addr=%02h byte=%02h", addr, a_rd_byte);
    endtask

    task automatic data_write(input logic [7:0] addr, input logic [7:0] data);
        ram_wr_en_data = 1'b1; ram_wr_addr = {8'h00, addr}; ram_wr_byte = data;
        step();
        ram_wr_en_data = 1'b0;
        data_model[addr & DMASK] = data;
    endtask

    task automatic data_read(input logic [7:0] addr, input string tag);
        ram_rd_en_data = 1'b1; ram_rd_addr = {8'h00, addr};
        step();
        ram_rd_en_data = 1'b0;
        chk({tag, "_vld"}, a_rd_vld, 1);
        chk(tag, a_rd_byte, data_model[addr & DMASK]);
        $display("txn data_read addr=%02h byte=%02h", addr, a_rd_byte);
    endtask

    task automatic xdata_write(input logic [11:0] addr, input logic [7:0] data);
        ram_wr_en_xdata = 1'b1; ram_wr_addr = {4'h0, addr}; ram_wr_byte = data;
        step();
        ram_wr_en_xdata = 1'b0;
        if (!(addr == 12'hFFF && data[0])) xdata_model[addr] = data;
    endtask

    // dut_a has one XDATA wait state: valid exactly two cycles after the enable.
    task automatic xdata_read(input logic [11:0] addr, input string tag);
        ram_rd_en_xdata = 1'b1; ram_rd_addr = {4'h0, addr};
        step();
        ram_rd_en_xdata = 1'b0;
        chk({tag, "_early"}, a_rd_vld, 0);
        step();
        chk({tag, "_vld"}, a_rd_vld, 1);
        chk(tag, a_rd_byte, xdata_model[addr]);
        $display("txn xdata_read addr=%03h byte=%02h", addr, a_rd_byte);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  b, a, ra;
        logic [11:0] xa;

        rom_img[0] = 8'h02; rom_img[1] = 8'h00; rom_img[2] = 8'h30; rom_img[3] = 8'hE4;
        for (int i = 0; i < 4; i++) dut_a.r_rom_mem[i] = rom_img[i];
        dut_b.r_rom_mem[16] = 8'hA5;

        step(); step();
        chk("rst_rom_vld",  a_rom_vld,  0);
        chk("rst_rom_byte", a_rom_byte, 0);
        chk("rst_rd_vld",   a_rd_vld,   0);
        chk("rst_rd_byte",  a_rd_byte,  0);
        chk("rst_tx_valid", a_tx_valid, 0);
        chk("rst_tx_data",  a_tx_data,  0);
        chk("rst_sim_done", a_sim_done, 0);
        chk("rst_sfr_err",  a_sfr_err,  0);
        chk("rst_b_rom_vld", b_rom_vld, 0);
        chk("rst_b_rd_vld",  b_rd_vld,  0);
        rst = 1'b0;
        step();

        // Back-to-back fetches with no wait states.
        for (int i = 0; i < 4; i++) begin
            rom_en = 1'b1; rom_addr = 16'(i);
            step();
            chk("rom_pipe_vld",  a_rom_vld,  1);
            chk("rom_pipe_byte", a_rom_byte, rom_img[i]);
            $display("txn rom_fetch addr=%04h byte=%02h", i, a_rom_byte);
        end
        rom_en = 1'b0;
        step();
        chk("rom_idle_vld",  a_rom_vld,  0);
        chk("rom_hold_byte", a_rom_byte, rom_img[3]);
        repeat (6) step();

        // Wait-state latencies on dut_b (ROM 2, XDATA 3) and dut_a (XDATA 1).
        xdata_write(12'h123, 8'h3C);
        rom_en = 1'b1; rom_addr = 16'h0010;
        ram_rd_en_xdata = 1'b1; ram_rd_addr = 16'h0123;
        step();
        rom_en = 1'b0; ram_rd_en_xdata = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step();
            chk("b_rom_vld_cycle", b_rom_vld, 32'(c == 3));
            chk("b_xrd_vld_cycle", b_rd_vld,  32'(c == 4));
            chk("a_xrd_vld_cycle", a_rd_vld,  32'(c == 2));
            if (c == 3) chk("b_rom_byte", b_rom_byte, 8'hA5);
            if (c == 4) chk("b_xrd_byte", b_rd_byte,  8'h3C);
            if (c == 2) chk("a_xrd_byte", a_rd_byte,  8'h3C);
        end

        // DATA read-first on a same-cycle write, then new value and alias.
        data_write(8'h20, 8'h11);
        ram_wr_en_data = 1'b1; ram_wr_addr = 16'h0020; ram_wr_byte = 8'h55;
        ram_rd_en_data = 1'b1; ram_rd_addr = 16'h0020;
        step();
        ram_wr_en_data = 1'b0; ram_rd_en_data = 1'b0;
        chk("data_rf_vld",  a_rd_vld,  1);
        chk("data_rf_byte", a_rd_byte, 8'h11);
        data_model[8'h20 & DMASK] = 8'h55;
        data_read(8'h20, "data_new");
`ifndef R8051_TYPE8052_EN
        data_read(8'hA0, "data_alias");
`endif

        // Overflow: nine SBUF writes into an eight-entry queue with no drain.
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            sfr_write(SBUF, b);
            if (i < 8) txq_model.push_back(b);
        end
        sfr_read(SCON, 8'h80, "scon_ovf");
        chk("tx_valid_full", a_tx_valid, 1);
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("tx_stream_valid", a_tx_valid, 1);
            chk("tx_stream_data",  a_tx_data,  txq_model.pop_front());
            $display("txn tx_pop byte=%02h", a_tx_data);
            step();
        end
        tx_ready = 1'b0;
        chk("tx_drained", a_tx_valid, 0);
        sfr_read(SCON, 8'h82, "scon_drained");
        sfr_write(SCON, 8'h00);
        sfr_read(SCON, 8'h02, "scon_cleared");

        // Push and pop in the same cycle while full: both accepted, no overflow.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            sfr_write(SBUF, b);
            txq_model.push_back(b);
        end
        sfr_read(SCON, 8'h00, "scon_full_noovf");
        tx_ready = 1'b1;
        b = 8'($urandom);
        sfr_write(SBUF, b);
        void'(txq_model.pop_front());
        txq_model.push_back(b);
        for (int k = 0; k < 8; k++) begin
            chk("tx_pp_data", a_tx_data, txq_model.pop_front());
            step();
        end
        tx_ready = 1'b0;
        chk("tx_pp_empty", a_tx_valid, 0);
        sfr_read(SCON, 8'h02, "scon_pp_noovf");
        sfr_read(SBUF, 8'h00, "sbuf_read");
        chk("sfr_err_mapped", a_sfr_err, 0);

        // Magic XDATA write and unmapped SFR accesses.
        xdata_write(12'hFFF, 8'h7E);
        chk("sim_done_plain", a_sim_done, 0);
        xdata_write(12'hFFF, 8'h01);
        chk("sim_done_set_a", a_sim_done, 1);
        chk("sim_done_set_b", b_sim_done, 1);
        xdata_read(12'hFFF, "xdata_magic_kept");
        chk("sim_done_sticky", a_sim_done, 1);
        sfr_read(8'h80, 8'h00, "sfr_unmapped_rd");
        chk("sfr_err_rd", a_sfr_err, 1);
        step();
        chk("sfr_err_pulse", a_sfr_err, 0);
        sfr_write(8'h85, 8'hFF);
        chk("sfr_err_wr", a_sfr_err, 1);
        step();

        // Random DATA / XDATA traffic against the array models.
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                a  = 8'($urandom);
                ra = ($urandom_range(0, 1) == 1) ? (a ^ ~DMASK) : a;
                data_write(a, b);
                data_read(ra, "rand_data");
            end else begin
                xa = 12'($urandom_range(0, 4094));
                xdata_write(xa, b);
                xdata_read(xa, "rand_xdata");
            end
        end
        repeat (4) step();

        // Reset during a pending XDATA read with three bytes queued.
        for (int i = 0; i < 3; i++) sfr_write(SBUF, 8'(8'h40 + i));
        chk("pre_rst_tx_valid", a_tx_valid, 1);
        ram_rd_en_xdata = 1'b1; ram_rd_addr = 16'h0123;
        step();
        ram_rd_en_xdata = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("rst_cancel_a_vld", a_rd_vld,   0);
            chk("rst_cancel_b_vld", b_rd_vld,   0);
            chk("rst_flush_txq",    a_tx_valid, 0);
            step();
        end
        chk("rst_sim_done_clr", a_sim_done, 0);
        sfr_read(SCON, 8'h02, "scon_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
